shift_arbiter_ctrl: RTL and testbench
=====================================

Name: shift_arbiter_ctrl

Overview:
- Shares one 16-bit rotate datapath between two requesters (req0 = ALU, req1 = address/immediate unit).
- Each requester issues logical-left-shift, arithmetic-right-shift or rotate-right operations.
- The block round-robin arbitrates, sequences the shared datapath through a small FSM, and returns a registered result with requester ID over a valid/ready response channel.
- It sits between the execute-stage requesters and the rotate datapath.

Parameters:
- W, 16, data width (fixed by the rotate datapath; only 16 is supported).
- CW, 4, shift-count width (log2 W).
- STATW, 8, width of per-requester completion counters.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_op  input  2  00 SLL, 01 SRA, 10 ROR, 11 reserved.
- req0_data  input  W  operand.
- req0_cnt  input  CW  shift/rotate amount.
- req1_valid, req1_ready, req1_op, req1_data, req1_cnt: same as req0, for requester 1.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer takes result.
- rsp_data  output  W  result.
- rsp_id  output  1  requester that owns the result.
- rsp_err  output  1  op was reserved (11).
- busy  output  1  FSM not in IDLE.
- done0_cnt  output  STATW  completed responses for requester 0; wraps.
- done1_cnt  output  STATW  completed responses for requester 1; wraps.

Behaviour:
- Reset (async on rst_n low): state=IDLE; rr_ptr=0; rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0; done counters=0; operand registers=0. Any in-flight operation is discarded.
- FSM states: IDLE, EXEC, RESP.
- IDLE, arbitration:
  - Only one reqX_valid: that requester is granted, regardless of rr_ptr.
  - Both valid: requester rr_ptr is granted.
  - reqX_ready is combinational: 1 only in IDLE for the granted requester.
  - On grant: capture op/data/cnt/id; rr_ptr <= ~granted id; go to EXEC.
  - Neither valid: stay in IDLE; rr_ptr unchanged.
- EXEC (exactly 1 cycle): the datapath computes from the captured operands. Result registers into rsp_data/rsp_id/rsp_err; rsp_valid <= 1; go to RESP.
- RESP:
  - Hold rsp_* stable while rsp_valid && !rsp_ready.
  - On rsp_ready: rsp_valid <= 0; increment done counter for rsp_id; go to IDLE.
  - No new grant in the handshake cycle.
- Latency and throughput: accept at cycle T -> rsp_valid high at T+2. Minimum spacing between accepts is 3 cycles when rsp_ready is held at 1.
- Arithmetic (k = cnt, k=0 is identity for all ops):
  - ROR: rotate right by k.
  - SLL: rotate right by (16-k) mod 16, then force bits [k-1:0] to 0.
  - SRA: rotate right by k, then force bits [15:16-k] to data[15].
  - Reserved op 11: rsp_data = data unchanged, rsp_err=1; still consumes a slot and counts as done.
- Boundaries:
  - A requester that drops valid in IDLE before grant is not served.
  - Operand changes after acceptance have no effect.
  - done counters wrap 255 -> 0.
  - Reset asserted in EXEC/RESP drops the result; nothing is counted.
- busy = (state != IDLE).

Decomposition:
- Shared package: op encodings (OP_SLL=2'b00, OP_SRA=2'b01, OP_ROR=2'b10, OP_RSV=2'b11), FSM state encodings, W/CW constants.
- Sub-module shift_core: combinational. Contains the existing 16-bit rotate-right datapath plus mask/sign-fill logic, with inputs op/data/cnt and outputs result/err. The arbiter FSM, counters and registers stay in shift_arbiter_ctrl.

Test Plan:
- Reset check: hold rst_n=0 with random inputs -> rsp_valid=0, busy=0, done0_cnt=done1_cnt=0, both ready=0.
- Single op: req0 ROR data=0x1234 cnt=4, rsp_ready=1 -> req0_ready at T; rsp_valid at T+2 with rsp_data=0x4123, rsp_id=0; done0_cnt=1.
- Op coverage:
  - SLL 0x8001 cnt1 -> 0x0002.
  - SLL 0x00FF cnt8 -> 0xFF00.
  - SRA 0x8000 cnt4 -> 0xF800.
  - SRA 0x7FF0 cnt4 -> 0x07FF.
  - any op with cnt0 on 0xABCD -> 0xABCD.
  - op 11 on 0x5A5A -> 0x5A5A, rsp_err=1.
- Contention: both valid continuously for 4 operations -> grants alternate 0,1,0,1 (rr_ptr starts 0); rsp_id sequence matches; accepts spaced 3 cycles.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_data/rsp_id stable, no ready asserted, busy=1; on rsp_ready=1, return to IDLE next cycle.
- Reset mid-op: deassert rst_n during EXEC -> rsp_valid=0 immediately; counters=0; after release, a new req1 is granted first only if req0 is idle; otherwise req0 wins (rr_ptr=0).

Source files
------------

// File: rtl/shift_arbiter_ctrl_pkg.sv
// Shared constants, operation and FSM encodings for the shift arbiter.
// Also hosts the rotate-right primitive used by the shared datapath.
package shift_arbiter_ctrl_pkg;

  localparam int W     = 16;
  localparam int CW    = 4;
  localparam int STATW = 8;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRA = 2'b01,
    OP_ROR = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  function automatic logic [W-1:0] ror16(input logic [W-1:0] d, input logic [CW-1:0] k);
    logic [2*W-1:0] dbl;
    dbl = {d, d} >> k;
    return dbl[W-1:0];
  endfunction

endpackage

// File: rtl/shift_arbiter_ctrl_shift_core.sv
// Combinational shared datapath: one rotate-right unit, with masking for SLL
// and sign fill for SRA layered on top of the rotated value.
module shift_core
  import shift_arbiter_ctrl_pkg::*;
(
  input  op_e           op,
  input  logic [W-1:0]  data,
  input  logic [CW-1:0] cnt,
  output logic [W-1:0]  result,
  output logic          err
);

  logic [CW-1:0] left_amt;
  logic [W-1:0]  rot_right;
  logic [W-1:0]  rot_left;
  logic [W-1:0]  low_mask;
  logic [W-1:0]  high_mask;

  // A left shift by k is a right rotate by (16-k) mod 16, i.e. the two's complement of k.
  assign left_amt  = ~cnt + CW'(1);
  assign rot_right = ror16(data, cnt);
  assign rot_left  = ror16(data, left_amt);
  assign low_mask  = (W'(1) << cnt) - W'(1);
  assign high_mask = ~({W{1'b1}} >> cnt);

  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    result = rot_right;
    err    = 1'b0;
    case (op)
      OP_SLL:  result = rot_left & ~low_mask;
      OP_SRA:  result = (rot_right & ~high_mask) | (data[W-1] ? high_mask : '0);
      OP_ROR:  result = rot_right;
      default: begin
        result = data;
        err    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/shift_arbiter_ctrl.sv
// Round-robin arbiter for two requesters sharing one shift datapath:
// IDLE grants and captures operands, EXEC computes, RESP holds the result until taken.
module shift_arbiter_ctrl
  import shift_arbiter_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [W-1:0]     req0_data,
  input  logic [CW-1:0]    req0_cnt,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [W-1:0]     req1_data,
  input  logic [CW-1:0]    req1_cnt,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [W-1:0]     rsp_data,
  output logic             rsp_id,
  output logic             rsp_err,
  output logic             busy,
  output logic [STATW-1:0] done0_cnt,
  output logic [STATW-1:0] done1_cnt
);

  state_e            state_q, state_d;
  logic              rr_ptr_q, rr_ptr_d;
  op_e               op_q, op_d;
  logic [W-1:0]      data_q, data_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              id_q, id_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [W-1:0]      rsp_data_q, rsp_data_d;
  logic              rsp_id_q, rsp_id_d;
  logic              rsp_err_q, rsp_err_d;
  logic [STATW-1:0]  done0_cnt_q, done0_cnt_d;
  logic [STATW-1:0]  done1_cnt_q, done1_cnt_d;

  logic              in_idle;
  logic              any_req;
  logic              grant_id;
  logic [W-1:0]      core_result;
  logic              core_err;

  // A lone requester wins outright; rr_ptr only breaks ties.
  assign in_idle  = (state_q == ST_IDLE);
  assign any_req  = req0_valid | req1_valid;
  assign grant_id = (req0_valid && req1_valid) ? rr_ptr_q : req1_valid;

  // Ready is masked by rst_n so nothing looks accepted while reset is held.
  assign req0_ready = rst_n && in_idle && any_req && !grant_id;
  assign req1_ready = rst_n && in_idle && any_req &&  grant_id;

  shift_core u_shift_core (
    .op     (op_q),
    .data   (data_q),
    .cnt    (cnt_q),
    .result (core_result),
    .err    (core_err)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    op_d        = op_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    rsp_err_d   = rsp_err_q;
    done0_cnt_d = done0_cnt_q;
    done1_cnt_d = done1_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          id_d     = grant_id;
          op_d     = grant_id ? op_e'(req1_op) : op_e'(req0_op);
          data_d   = grant_id ? req1_data : req0_data;
          cnt_d    = grant_id ? req1_cnt  : req0_cnt;
          rr_ptr_d = ~grant_id;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_data_d  = core_result;
        rsp_err_d   = core_err;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (rsp_id_q) done1_cnt_d = done1_cnt_q + STATW'(1);
          else          done0_cnt_d = done0_cnt_q + STATW'(1);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= 1'b0;
      // NOTE: operand registers are reset too, so a dropped operation leaves no stale data behind.
      op_q        <= OP_SLL;
      data_q      <= '0;
      cnt_q       <= '0;
      id_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      done0_cnt_q <= '0;
      done1_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      op_q        <= op_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      rsp_err_q   <= rsp_err_d;
      done0_cnt_q <= done0_cnt_d;
      done1_cnt_q <= done1_cnt_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = !in_idle;
  assign done0_cnt = done0_cnt_q;
  assign done1_cnt = done1_cnt_q;

endmodule

// File: tb/tb_shift_arbiter_ctrl.sv
// Self-checking bench for shift_arbiter_ctrl: directed vector table, corner
// sequences and randomized traffic against a transaction-level reference model.
module tb_shift_arbiter_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [1:0]  req0_op = '0, req1_op = '0;
  logic [15:0] req0_data = '0, req1_data = '0;
  logic [3:0]  req0_cnt = '0, req1_cnt = '0;
  logic        rsp_valid, rsp_id, rsp_err, busy;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic [7:0]  done0_cnt, done1_cnt;

  always #5 clk = ~clk;

  shift_arbiter_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_data(req0_data), .req0_cnt(req0_cnt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_data(req1_data), .req1_cnt(req1_cnt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_err(rsp_err), .busy(busy),
    .done0_cnt(done0_cnt), .done1_cnt(done1_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bit-by-bit definition of each operation, independent of any rotator.
  function automatic logic [16:0] ref_op(input logic [1:0] op, input logic [15:0] d, input int k);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) begin
      case (op)
        2'b00:   r[i] = (i >= k) ? d[i-k] : 1'b0;
        2'b01:   r[i] = (i + k < 16) ? d[i+k] : d[15];
        2'b10:   r[i] = d[(i+k)%16];
        default: r[i] = d[i];
      endcase
    end
    return {op == 2'b11, r};
  endfunction

  // Reference model: one transaction in flight, its age in cycles since accept.
  bit          m_busy;
  int          m_age;
  bit          m_pref;
  logic        m_id, m_err;
  logic [15:0] m_data;
  logic [7:0]  m_done0, m_done1;
  int          cyc = 0;
  int          grant_ids[$];
  int          grant_cycs[$];

  logic [1:0]  nx_op0, nx_op1;
  logic [15:0] nx_data0, nx_data1;
  logic [3:0]  nx_cnt0, nx_cnt1;

  task automatic model_reset();
    m_busy = 0; m_age = 0; m_pref = 0; m_done0 = '0; m_done1 = '0;
  endtask

  task automatic randomize_next();
    nx_op0 = 2'($urandom_range(0, 3)); nx_data0 = 16'($urandom); nx_cnt0 = 4'($urandom);
    nx_op1 = 2'($urandom_range(0, 3)); nx_data1 = 16'($urandom); nx_cnt1 = 4'($urandom);
  endtask

  task automatic step(input bit v0, input bit v1, input bit rr, input bit rnd);
    bit g0, g1;
    logic [16:0] res;
    @(negedge clk);
    cyc++;
    if (rnd) randomize_next();
    req0_valid = v0; req0_op = nx_op0; req0_data = nx_data0; req0_cnt = nx_cnt0;
    req1_valid = v1; req1_op = nx_op1; req1_data = nx_data1; req1_cnt = nx_cnt1;
    rsp_ready  = rr;
    #1;
    g0 = !m_busy && v0 && (!v1 || !m_pref);
    g1 = !m_busy && v1 && (!v0 ||  m_pref);
    check("req0_ready", 32'(req0_ready), 32'(g0));
    check("req1_ready", 32'(req1_ready), 32'(g1));
    check("busy", 32'(busy), 32'(m_busy));
    check("rsp_valid", 32'(rsp_valid), 32'(m_busy && m_age >= 2));
    if (m_busy && m_age >= 2) begin
      check("rsp_data", 32'(rsp_data), 32'(m_data));
      check("rsp_id", 32'(rsp_id), 32'(m_id));
      check("rsp_err", 32'(rsp_err), 32'(m_err));
    end
    check("done0_cnt", 32'(done0_cnt), 32'(m_done0));
    check("done1_cnt", 32'(done1_cnt), 32'(m_done1));
    if (req0_ready || req1_ready) begin
      grant_ids.push_back(int'(req1_ready));
      grant_cycs.push_back(cyc);
    end
    if (m_busy) begin
      if (m_age >= 2 && rr) begin
        if (m_id) m_done1++; else m_done0++;
        m_busy = 0;
      end else begin
        m_age++;
      end
    end else if (g0 || g1) begin
      res    = g1 ? ref_op(nx_op1, nx_data1, int'(nx_cnt1)) : ref_op(nx_op0, nx_data0, int'(nx_cnt0));
      m_busy = 1; m_age = 1; m_id = g1; m_err = res[16]; m_data = res[15:0];
      m_pref = !g1;
    end
  endtask

  task automatic apply_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rst_n = 1'b0;
      randomize_next();
      req0_valid = 1'($urandom); req1_valid = 1'b1; rsp_ready = 1'($urandom);
      req0_op = nx_op0; req0_data = nx_data0; req0_cnt = nx_cnt0;
      req1_op = nx_op1; req1_data = nx_data1; req1_cnt = nx_cnt1;
      #1;
      check("rst_rsp_valid", 32'(rsp_valid), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done0", 32'(done0_cnt), 0);
      check("rst_done1", 32'(done1_cnt), 0);
      check("rst_req0_ready", 32'(req0_ready), 0);
      check("rst_req1_ready", 32'(req1_ready), 0);
      check("rst_rsp_data", 32'(rsp_data), 0);
    end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic        id;
    logic [1:0]  op;
    logic [15:0] data;
    logic [3:0]  cnt;
    logic [15:0] exp;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vecs.push_back('{1'b0, 2'b10, 16'h1234, 4'd4,  16'h4123, 1'b0});
    vecs.push_back('{1'b1, 2'b00, 16'h8001, 4'd1,  16'h0002, 1'b0});
    vecs.push_back('{1'b0, 2'b00, 16'h00FF, 4'd8,  16'hFF00, 1'b0});
    vecs.push_back('{1'b1, 2'b01, 16'h8000, 4'd4,  16'hF800, 1'b0});
    vecs.push_back('{1'b0, 2'b01, 16'h7FF0, 4'd4,  16'h07FF, 1'b0});
    vecs.push_back('{1'b1, 2'b00, 16'hABCD, 4'd0,  16'hABCD, 1'b0});
    vecs.push_back('{1'b0, 2'b01, 16'hABCD, 4'd0,  16'hABCD, 1'b0});
    vecs.push_back('{1'b1, 2'b10, 16'hABCD, 4'd0,  16'hABCD, 1'b0});
    vecs.push_back('{1'b0, 2'b11, 16'h5A5A, 4'd3,  16'h5A5A, 1'b1});
    vecs.push_back('{1'b1, 2'b10, 16'h0001, 4'd15, 16'h0002, 1'b0});
    vecs.push_back('{1'b0, 2'b01, 16'h8000, 4'd15, 16'hFFFF, 1'b0});
    vecs.push_back('{1'b1, 2'b00, 16'h0001, 4'd15, 16'h8000, 1'b0});

    model_reset();
    randomize_next();
    apply_reset();

    // Directed vectors: accept, EXEC, then the response two cycles after accept.
    foreach (vecs[i]) begin
      randomize_next();
      if (vecs[i].id) begin
        nx_op1 = vecs[i].op; nx_data1 = vecs[i].data; nx_cnt1 = vecs[i].cnt;
      end else begin
        nx_op0 = vecs[i].op; nx_data0 = vecs[i].data; nx_cnt0 = vecs[i].cnt;
      end
      step(!vecs[i].id, vecs[i].id, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b1, 1'b1);
      check($sformatf("vec%0d_data", i), 32'(rsp_data), 32'(vecs[i].exp));
      check($sformatf("vec%0d_err", i), 32'(rsp_err), 32'(vecs[i].err));
      check($sformatf("vec%0d_id", i), 32'(rsp_id), 32'(vecs[i].id));
    end
    step(1'b0, 1'b0, 1'b1, 1'b1);
    check("vec_done0_total", 32'(done0_cnt), 6);
    check("vec_done1_total", 32'(done1_cnt), 6);

    // Contention from a fresh reset: grants alternate starting at requester 0.
    apply_reset();
    grant_ids.delete(); grant_cycs.delete();
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b1, 1'b1);
    check("contention_grants", 32'(grant_ids.size() >= 4), 1);
    if (grant_ids.size() >= 4) begin
      for (int i = 0; i < 4; i++) check($sformatf("contention_id%0d", i), 32'(grant_ids[i]), 32'(i % 2));
      for (int i = 1; i < 4; i++)
        check($sformatf("contention_gap%0d", i), 32'(grant_cycs[i] - grant_cycs[i-1]), 3);
    end

    // Backpressure: five stalled RESP cycles with both requesters pushing.
    apply_reset();
    step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
    check("bp_busy", 32'(busy), 1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    check("bp_idle_after", 32'(busy), 0);
    check("bp_done1", 32'(done1_cnt), 1);

    // Reset during EXEC after a req0 grant (leaves rr_ptr at 1 if not reset).
    step(1'b1, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    check("midrst_rsp_valid", 32'(rsp_valid), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_done1", 32'(done1_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check("midrst_req0_wins", 32'(req0_ready), 1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check("midrst_lone_req1", 32'(req1_ready), 1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 3) != 0), 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 1'b1);

    // Counter wrap: 256 completions for requester 0 return done0_cnt to 0.
    apply_reset();
    for (int i = 0; i < 256; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b1, 1'b1);
    end
    step(1'b0, 1'b0, 1'b1, 1'b1);
    check("wrap_done0", 32'(done0_cnt), 0);
    check("wrap_done1", 32'(done1_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
